// File: rtl/pc_seq_pkg.sv
// ----------------------------------------------------------------------------
// pc_seq_pkg
// Shared definitions for the program-flow sequencer: control-transfer opcode
// fields, branch-condition encodings, the sequencer FSM state type and a
// helper that evaluates a branch condition against the registered flags.
// ----------------------------------------------------------------------------
package pc_seq_pkg;

    // Opcode fields, compared against the top bits of the instruction word.
    localparam logic [2:0] OP_BR  = 3'b101;     // t[5:3]
    localparam logic [4:0] OP_JMP = 5'b11100;   // t[5:1]
    localparam logic [4:0] OP_JSB = 5'b11101;   // t[5:1]
    localparam logic [5:0] OP_RET = 6'b111100;  // t[5:0]

    // Branch condition field t[2:1].
    typedef enum logic [1:0] {
        COND_Z  = 2'b00,  // BZ : taken when Z=1
        COND_NZ = 2'b01,  // BNZ: taken when Z=0
        COND_C  = 2'b10,  // BC : taken when C=1
        COND_NC = 2'b11   // BNC: taken when C=0
    } cond_e;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_e;

    function automatic logic cond_met(input cond_e cond, input logic z, input logic c);
        logic met;
        case (cond)
            COND_Z:  met = z;
            COND_NZ: met = ~z;
            COND_C:  met = c;
            default: met = ~c;
        endcase
        return met;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// ----------------------------------------------------------------------------
// ras_stack
// Hardware return-address stack. Push writes push_data above the current top,
// pop discards the top entry. A push when full and a pop when empty are
// ignored, so the pointer never wraps. The caller guarantees push and pop are
// never asserted together.
//
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset (empties the stack)
//   push       in   push push_data
//   pop        in   discard the top entry
//   push_data  in   WIDTH-bit value to push
//   top        out  current top-of-stack value (undefined when empty)
//   count      out  occupancy, 0..DEPTH
//   full       out  count == DEPTH
//   empty      out  count == 0
// ----------------------------------------------------------------------------
module ras_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 12
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         top,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_count;
    logic [PTR_W:0]   w_count_m1;
    logic [PTR_W-1:0] w_top_idx;
    logic [PTR_W-1:0] w_push_idx;

    assign full       = (r_count == FULL_CNT);
    assign empty      = (r_count == '0);
    assign w_count_m1 = r_count - (PTR_W+1)'(1);
    assign w_top_idx  = w_count_m1[PTR_W-1:0];
    assign w_push_idx = r_count[PTR_W-1:0];
    assign top        = r_mem[w_top_idx];
    assign count      = r_count;

    // NOTE: the storage array has no reset; only the occupancy counter decides
    // which entries are live, so clearing the array would buy nothing.
    always_ff @(posedge clock) begin
        if (push && !full) begin
            r_mem[w_push_idx] <= push_data;
        end
    end

    // NOTE: sequential state is always assigned with <= so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (push && !full) begin
            r_count <= r_count + (PTR_W+1)'(1);
        end else if (pop && !empty) begin
            r_count <= w_count_m1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
// Program-flow unit for the 19-bit pipelined core. Decodes JMP, conditional
// branch, JSB and RET, keeps the registered Z/C flags, owns the return-address
// stack and issues a one-cycle registered PC redirect followed by a
// FLUSH_CYCLES-long stall/flush window to fetch and decode.
//
// Ports:
//   clock, reset_n       clock and asynchronous active-low reset
//   instr_valid          instr/pc_cur carry a decoded instruction
//   instr, pc_cur        instruction word and its address
//   alu_zero, alu_carry  execute-stage flag results
//   flags_we             load alu_zero/alu_carry into Z/C
//   err_clear            clear the sticky stack error flags
//   pc_load, pc_next     one-cycle redirect strobe and its target
//   stall, flush         hold fetch / squash decode during the bubble window
//   zero_flag, carry_flag registered Z and C
//   sp_count             return-stack occupancy
//   stack_overflow       sticky: JSB on a full stack (push dropped)
//   stack_underflow      sticky: RET on an empty stack (no redirect)
// ----------------------------------------------------------------------------
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int INSTR_W      = 19,
    parameter int ADDR_W       = 12,
    parameter int STACK_DEPTH  = 8,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           instr_valid,
    input  logic [INSTR_W-1:0]             instr,
    input  logic [ADDR_W-1:0]              pc_cur,
    input  logic                           alu_zero,
    input  logic                           alu_carry,
    input  logic                           flags_we,
    input  logic                           err_clear,
    output logic                           pc_load,
    output logic [ADDR_W-1:0]              pc_next,
    output logic                           stall,
    output logic                           flush,
    output logic                           zero_flag,
    output logic                           carry_flag,
    output logic [$clog2(STACK_DEPTH):0]   sp_count,
    output logic                           stack_overflow,
    output logic                           stack_underflow
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYCLES - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_pc_load;
    logic [ADDR_W-1:0] r_pc_next;
    logic              r_stall;
    logic              r_flush;
    logic              r_zero;
    logic              r_carry;
    logic              r_overflow;
    logic              r_underflow;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [5:0]        w_t;
    logic              w_is_br;
    logic              w_is_jmp;
    logic              w_is_jsb;
    logic              w_is_ret;
    logic [ADDR_W-1:0] w_pc_plus1;
    logic [ADDR_W-1:0] w_offset;
    logic [ADDR_W-1:0] w_abs_target;
    logic              w_active;
    logic              w_unused_instr;

    assign w_t          = instr[INSTR_W-1 -: 6];
    assign w_is_br      = (w_t[5:3] == OP_BR);
    assign w_is_jmp     = (w_t[5:1] == OP_JMP);
    assign w_is_jsb     = (w_t[5:1] == OP_JSB);
    assign w_is_ret     = (w_t == OP_RET);
    assign w_pc_plus1   = pc_cur + ADDR_W'(1);
    assign w_offset     = {{(ADDR_W-8){instr[7]}}, instr[7:0]};
    assign w_abs_target = instr[ADDR_W-1:0];
    // Instructions are only acted on in RUN; during FLUSH they are squashed.
    assign w_active     = instr_valid && (r_state == S_RUN);
    // Not every instruction bit feeds this block.
    assign w_unused_instr = ^instr;

    // ------------------------------------------------------------------
    // Return-address stack
    // ------------------------------------------------------------------
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_top;
    logic              w_full;
    logic              w_empty;

    ras_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_W)
    ) u_ras (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_plus1),
        .top       (w_top),
        .count     (sp_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    // ------------------------------------------------------------------
    // Next-PC decision
    // ------------------------------------------------------------------
    logic              w_taken;
    logic [ADDR_W-1:0] w_target;
    logic              w_set_ovf;
    logic              w_set_unf;

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_taken   = 1'b0;
        w_target  = '0;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_set_ovf = 1'b0;
        w_set_unf = 1'b0;
        if (w_active) begin
            if (w_is_br) begin
                // Conditions use the registered flags, never this cycle's ALU.
                w_taken  = cond_met(cond_e'(w_t[2:1]), r_zero, r_carry);
                w_target = w_pc_plus1 + w_offset;
            end else if (w_is_jmp) begin
                w_taken  = 1'b1;
                w_target = w_abs_target;
            end else if (w_is_jsb) begin
                // The call still happens on a full stack; only the push is lost.
                w_taken   = 1'b1;
                w_target  = w_abs_target;
                w_push    = !w_full;
                w_set_ovf = w_full;
            end else if (w_is_ret) begin
                // A return with nothing to return to is reported, not taken.
                w_taken   = !w_empty;
                w_target  = w_top;
                w_pop     = !w_empty;
                w_set_unf = w_empty;
            end
        end
    end

    // ------------------------------------------------------------------
    // Redirect / flush FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_RUN;
            r_cnt     <= '0;
            r_pc_load <= 1'b0;
            r_pc_next <= '0;
            r_stall   <= 1'b0;
            r_flush   <= 1'b0;
        end else begin
            r_pc_load <= 1'b0;
            case (r_state)
                S_RUN: begin
                    if (w_taken) begin
                        r_pc_load <= 1'b1;
                        r_pc_next <= w_target;
                        r_stall   <= 1'b1;
                        r_flush   <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    // r_cnt counts bubble cycles already shown on stall/flush.
                    if (r_cnt == CNT_LAST) begin
                        r_stall <= 1'b0;
                        r_flush <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Flags and sticky errors
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
        end else if (flags_we) begin
            r_zero  <= alu_zero;
            r_carry <= alu_carry;
        end
    end

    // A new error in the same cycle as err_clear leaves the flag set.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_set_ovf) begin
                r_overflow <= 1'b1;
            end else if (err_clear) begin
                r_overflow <= 1'b0;
            end
            if (w_set_unf) begin
                r_underflow <= 1'b1;
            end else if (err_clear) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign pc_load         = r_pc_load;
    assign pc_next         = r_pc_next;
    assign stall           = r_stall;
    assign flush           = r_flush;
    assign zero_flag       = r_zero;
    assign carry_flag      = r_carry;
    assign stack_overflow  = r_overflow;
    assign stack_underflow = r_underflow;

endmodule

// File: tb/tb_pc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pc_sequencer
// Directed bench for pc_sequencer with STACK_DEPTH=8 and FLUSH_CYCLES=3.
// Inputs change and outputs are observed 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam int INSTR_W = 19;
    localparam int ADDR_W  = 12;
    localparam int DEPTH   = 8;
    localparam int FC      = 3;

    localparam logic [1:0] C_Z  = 2'b00;
    localparam logic [1:0] C_NZ = 2'b01;
    localparam logic [1:0] C_C  = 2'b10;
    localparam logic [1:0] C_NC = 2'b11;

    logic               clock;
    logic               reset_n;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc_cur;
    logic               alu_zero;
    logic               alu_carry;
    logic               flags_we;
    logic               err_clear;
    logic               pc_load;
    logic [ADDR_W-1:0]  pc_next;
    logic               stall;
    logic               flush;
    logic               zero_flag;
    logic               carry_flag;
    logic [3:0]         sp_count;
    logic               stack_overflow;
    logic               stack_underflow;

    int errors = 0;
    int checks = 0;

    pc_sequencer #(
        .INSTR_W      (INSTR_W),
        .ADDR_W       (ADDR_W),
        .STACK_DEPTH  (DEPTH),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .pc_cur          (pc_cur),
        .alu_zero        (alu_zero),
        .alu_carry       (alu_carry),
        .flags_we        (flags_we),
        .err_clear       (err_clear),
        .pc_load         (pc_load),
        .pc_next         (pc_next),
        .stall           (stall),
        .flush           (flush),
        .zero_flag       (zero_flag),
        .carry_flag      (carry_flag),
        .sp_count        (sp_count),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- instruction builders ----------------
    function automatic logic [INSTR_W-1:0] f_br(input logic [1:0] c, input logic [7:0] off);
        return {3'b101, c, 6'b000000, off};
    endfunction
    function automatic logic [INSTR_W-1:0] f_jmp(input logic [ADDR_W-1:0] a);
        return {5'b11100, 2'b00, a};
    endfunction
    function automatic logic [INSTR_W-1:0] f_jsb(input logic [ADDR_W-1:0] a);
        return {5'b11101, 2'b00, a};
    endfunction
    function automatic logic [INSTR_W-1:0] f_ret();
        return {6'b111100, 13'd0};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [INSTR_W-1:0] ins, input logic [ADDR_W-1:0] pc);
        instr_valid = 1'b1;
        instr       = ins;
        pc_cur      = pc;
        tick();
        instr_valid = 1'b0;
        instr       = '0;
    endtask

    task automatic set_flags(input logic z, input logic c);
        flags_we  = 1'b1;
        alu_zero  = z;
        alu_carry = c;
        tick();
        flags_we  = 1'b0;
    endtask

    // Called in cycle k+1 after a transfer: checks the redirect strobe and the
    // full bubble window, ending in the first RUN cycle after it.
    task automatic expect_redirect(input string name, input logic [ADDR_W-1:0] exp_pc);
        checks++;
        if (pc_load !== 1'b1 || pc_next !== exp_pc) begin
            errors++;
            $display("FAIL %s redirect: pc_load=%b pc_next=%h, expected pc_load=1 pc_next=%h",
                     name, pc_load, pc_next, exp_pc);
        end
        for (int i = 0; i < FC; i++) begin
            checks++;
            if (stall !== 1'b1 || flush !== 1'b1 || (i > 0 && pc_load !== 1'b0)) begin
                errors++;
                $display("FAIL %s bubble %0d: stall=%b flush=%b pc_load=%b, expected 1 1 %b",
                         name, i, stall, flush, pc_load, (i == 0));
            end
            tick();
        end
        checks++;
        if (stall !== 1'b0 || flush !== 1'b0 || pc_load !== 1'b0) begin
            errors++;
            $display("FAIL %s window end: stall=%b flush=%b pc_load=%b, expected 0 0 0",
                     name, stall, flush, pc_load);
        end
    endtask

    task automatic expect_no_redirect(input string name);
        checks++;
        if (pc_load !== 1'b0 || stall !== 1'b0 || flush !== 1'b0) begin
            errors++;
            $display("FAIL %s: pc_load=%b stall=%b flush=%b, expected 0 0 0",
                     name, pc_load, stall, flush);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        instr_valid = 1'b0;
        instr       = '0;
        pc_cur      = '0;
        alu_zero    = 1'b0;
        alu_carry   = 1'b0;
        flags_we    = 1'b0;
        err_clear   = 1'b0;
        reset_n     = 1'b0;
        #12;
        checks++;
        if ({pc_load, pc_next, stall, flush, zero_flag, carry_flag, sp_count,
             stack_overflow, stack_underflow} !== '0) begin
            errors++;
            $display("FAIL reset_initial: pc_load=%b pc_next=%h stall=%b sp=%0d, expected all 0",
                     pc_load, pc_next, stall, sp_count);
        end
        reset_n = 1'b1;
        tick();

        // Enter FLUSH, reach the second bubble, then reset asynchronously.
        issue(f_jmp(12'h123), 12'h000);
        checks++;
        if (pc_load !== 1'b1 || pc_next !== 12'h123 || stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_jmp: pc_load=%b pc_next=%h stall=%b, expected 1 123 1",
                     pc_load, pc_next, stall);
        end
        tick();
        checks++;
        if (stall !== 1'b1 || pc_load !== 1'b0) begin
            errors++;
            $display("FAIL reset_second_bubble: stall=%b pc_load=%b, expected 1 0", stall, pc_load);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({pc_load, pc_next, stall, flush, zero_flag, carry_flag, sp_count,
             stack_overflow, stack_underflow} !== '0) begin
            errors++;
            $display("FAIL reset_mid_flush: pc_load=%b pc_next=%h stall=%b flush=%b sp=%0d, expected all 0",
                     pc_load, pc_next, stall, flush, sp_count);
        end
        #2 reset_n = 1'b1;
        tick();
        checks++;
        if (stall !== 1'b0 || flush !== 1'b0 || sp_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_release: stall=%b flush=%b sp=%0d, expected 0 0 0",
                     stall, flush, sp_count);
        end
        // FSM must be in RUN: a jump is taken immediately.
        issue(f_jmp(12'h0AA), 12'h005);
        expect_redirect("reset_run_jmp", 12'h0AA);
    endtask

    task automatic test_branches();
        set_flags(1'b1, 1'b0);
        checks++;
        if (zero_flag !== 1'b1 || carry_flag !== 1'b0) begin
            errors++;
            $display("FAIL flags_load: Z=%b C=%b, expected 1 0", zero_flag, carry_flag);
        end
        issue(f_br(C_Z, 8'hFE), 12'h010);
        expect_redirect("bz_taken", 12'h00F);

        set_flags(1'b0, 1'b0);
        issue(f_br(C_Z, 8'hFE), 12'h010);
        expect_no_redirect("bz_not_taken");
        issue(f_br(C_NZ, 8'h05), 12'h020);
        expect_redirect("bnz_taken", 12'h026);
        issue(f_br(C_C, 8'h10), 12'h030);
        expect_no_redirect("bc_not_taken");
        issue(f_br(C_NC, 8'h80), 12'h100);
        expect_redirect("bnc_taken_neg", 12'h081);

        set_flags(1'b0, 1'b1);
        issue(f_br(C_NC, 8'h10), 12'h200);
        expect_no_redirect("bnc_not_taken");
        issue(f_br(C_C, 8'h10), 12'h200);
        expect_redirect("bc_taken", 12'h211);
    endtask

    task automatic test_flag_timing();
        // Z is 0 here; load Z=1 in the same cycle as a BZ.
        instr_valid = 1'b1;
        instr       = f_br(C_Z, 8'hFE);
        pc_cur      = 12'h010;
        flags_we    = 1'b1;
        alu_zero    = 1'b1;
        alu_carry   = 1'b1;
        tick();
        instr_valid = 1'b0;
        flags_we    = 1'b0;
        checks++;
        if (pc_load !== 1'b0 || stall !== 1'b0 || zero_flag !== 1'b1) begin
            errors++;
            $display("FAIL flag_same_cycle: pc_load=%b stall=%b Z=%b, expected 0 0 1",
                     pc_load, stall, zero_flag);
        end
        issue(f_br(C_Z, 8'hFE), 12'h010);
        expect_redirect("flag_next_cycle", 12'h00F);

        // flags_we still loads during FLUSH.
        issue(f_jmp(12'h040), 12'h000);
        flags_we  = 1'b1;
        alu_zero  = 1'b0;
        alu_carry = 1'b0;
        tick();
        flags_we  = 1'b0;
        checks++;
        if (stall !== 1'b1 || zero_flag !== 1'b0 || carry_flag !== 1'b0) begin
            errors++;
            $display("FAIL flags_in_flush: stall=%b Z=%b C=%b, expected 1 0 0",
                     stall, zero_flag, carry_flag);
        end
        tick();
        tick();
    endtask

    task automatic test_call_return();
        issue(f_jsb(12'h200), 12'h050);
        checks++;
        if (sp_count !== 4'd1) begin
            errors++;
            $display("FAIL jsb_sp: sp_count=%0d, expected 1", sp_count);
        end
        expect_redirect("jsb_single", 12'h200);
        issue(f_ret(), 12'h210);
        checks++;
        if (sp_count !== 4'd0) begin
            errors++;
            $display("FAIL ret_sp: sp_count=%0d, expected 0", sp_count);
        end
        expect_redirect("ret_single", 12'h051);

        for (int i = 0; i < DEPTH; i++) begin
            logic [ADDR_W-1:0] pc;
            pc = 12'h100 + ADDR_W'(16 * i);
            issue(f_jsb(12'h300 + ADDR_W'(i)), pc);
            checks++;
            if (sp_count !== 4'(i + 1)) begin
                errors++;
                $display("FAIL nest_push_%0d: sp_count=%0d, expected %0d", i, sp_count, i + 1);
            end
            expect_redirect("nest_push", 12'h300 + ADDR_W'(i));
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            issue(f_ret(), 12'h300 + ADDR_W'(i));
            checks++;
            if (sp_count !== 4'(i)) begin
                errors++;
                $display("FAIL nest_pop_%0d: sp_count=%0d, expected %0d", i, sp_count, i);
            end
            expect_redirect("nest_pop", 12'h101 + ADDR_W'(16 * i));
        end
    endtask

    task automatic test_stack_errors();
        for (int i = 0; i < DEPTH; i++) begin
            issue(f_jsb(12'h300 + ADDR_W'(i)), 12'h100 + ADDR_W'(16 * i));
            expect_redirect("fill", 12'h300 + ADDR_W'(i));
        end
        issue(f_jsb(12'h3AB), 12'h400);
        checks++;
        if (stack_overflow !== 1'b1 || sp_count !== 4'd8) begin
            errors++;
            $display("FAIL overflow: ovf=%b sp_count=%0d, expected 1 8", stack_overflow, sp_count);
        end
        expect_redirect("overflow_jump", 12'h3AB);

        // The dropped push must not have disturbed the top entry.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            issue(f_ret(), 12'h000);
            expect_redirect("drain", 12'h101 + ADDR_W'(16 * i));
        end

        issue(f_ret(), 12'h123);
        expect_no_redirect("underflow_no_redirect");
        checks++;
        if (stack_underflow !== 1'b1 || sp_count !== 4'd0 || stack_overflow !== 1'b1) begin
            errors++;
            $display("FAIL underflow: unf=%b ovf=%b sp=%0d, expected 1 1 0",
                     stack_underflow, stack_overflow, sp_count);
        end

        // Set wins over clear for underflow; overflow is simply cleared.
        instr_valid = 1'b1;
        instr       = f_ret();
        err_clear   = 1'b1;
        tick();
        instr_valid = 1'b0;
        err_clear   = 1'b0;
        checks++;
        if (stack_underflow !== 1'b1 || stack_overflow !== 1'b0) begin
            errors++;
            $display("FAIL set_wins: unf=%b ovf=%b, expected 1 0", stack_underflow, stack_overflow);
        end

        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        checks++;
        if (stack_underflow !== 1'b0 || stack_overflow !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: unf=%b ovf=%b, expected 0 0", stack_underflow, stack_overflow);
        end
    endtask

    task automatic test_flush_mask();
        issue(f_jmp(12'h3FF), 12'h000);
        checks++;
        if (pc_load !== 1'b1 || pc_next !== 12'h3FF) begin
            errors++;
            $display("FAIL mask_first: pc_load=%b pc_next=%h, expected 1 3ff", pc_load, pc_next);
        end
        instr_valid = 1'b1;
        instr       = f_jmp(12'h100);
        pc_cur      = 12'h001;
        tick();
        instr_valid = 1'b0;
        checks++;
        if (pc_load !== 1'b0 || pc_next !== 12'h3FF || stall !== 1'b1) begin
            errors++;
            $display("FAIL mask_second: pc_load=%b pc_next=%h stall=%b, expected 0 3ff 1",
                     pc_load, pc_next, stall);
        end
        tick();
        tick();
        checks++;
        if (pc_load !== 1'b0 || stall !== 1'b0 || pc_next !== 12'h3FF) begin
            errors++;
            $display("FAIL mask_end: pc_load=%b stall=%b pc_next=%h, expected 0 0 3ff",
                     pc_load, stall, pc_next);
        end
    endtask

    task automatic test_offset_wrap();
        set_flags(1'b1, 1'b0);
        issue(f_br(C_Z, 8'h7F), 12'hFF0);
        expect_redirect("offset_wrap", 12'h070);
    endtask

    task automatic test_back_to_back();
        // A transfer in the first RUN cycle after a window is taken at once.
        issue(f_jmp(12'h0C0), 12'h000);
        expect_redirect("b2b_first", 12'h0C0);
        issue(f_jmp(12'h0D0), 12'h0C0);
        expect_redirect("b2b_second", 12'h0D0);
    endtask

    initial begin
        test_reset();
        test_branches();
        test_flag_timing();
        test_call_return();
        test_stack_errors();
        test_flush_mask();
        test_offset_wrap();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
